xmul_limb_seq: RTL and testbench

//  Requester/sequencer driving the 3-operand extended multiplier (MADDL/MADDH, 2-cycle fixed latency).

---
 rtl/xmul_limb_seq.sv | 204 ++++++++++++++++++++
 tb/tb_xmul_limb_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xmul_limb_seq.sv
// Sequencer for r = a*b + c in radix 2^57, driving a 2-cycle MADDL/MADDH multiplier.
// One request per cycle; responses accumulate into an unreduced (NLIMB+1)-limb result.
module xmul_limb_seq #(
  parameter int NLIMB = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] b_in,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [3:0]  wr_idx,
  input  logic [63:0] wr_data,
  input  logic [4:0]  rd_idx,
  output logic [63:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        mul_req_valid,
  output logic        mul_req_dw,
  output logic [5:0]  mul_req_fn,
  output logic [4:0]  mul_req_tag,
  output logic [63:0] mul_req_in1,
  output logic [63:0] mul_req_in2,
  output logic [63:0] mul_req_in3,
  input  logic [63:0] mul_resp_data,
  input  logic [4:0]  mul_resp_tag
);
  localparam int NREQ = 2 * NLIMB;
  localparam logic [63:0] MASK57 = {7'd0, {57{1'b1}}};
  localparam logic [5:0] FN_MADDL = 6'd50;
  localparam logic [5:0] FN_MADDH = 6'd51;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [63:0] b_q;
  logic        busy_q, done_q, pend0_q, pend1_q;
  logic        req_valid_q;
  logic [5:0]  req_fn_q;
  logic [4:0]  req_tag_q;
  logic [63:0] req_in1_q, req_in2_q, req_in3_q;
  logic        wrp_valid_q, wrp_sel_q;
  logic [3:0]  wrp_idx_q;
  logic [63:0] wrp_data_q;
  logic [63:0] a_q [NLIMB];
  logic [63:0] c_q [NLIMB];
  logic [63:0] r_q [NLIMB+1];

  logic        start_acc, wr_open, issue_now;
  logic        wr_go, wr_go_sel;
  logic [3:0]  wr_go_idx;
  logic [63:0] wr_go_data;
  logic [3:0]  req_idx;
  logic        req_hi;
  logic [63:0] req_a, req_c, req_b;
  logic [4:0]  cap_idx;

  assign start_acc = start && (state_q == S_IDLE);
  assign wr_open   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign issue_now = start_acc || ((state_q == S_ISSUE) && (cnt_q != 6'(NREQ)));
  assign req_idx   = cnt_q[4:1];
  assign req_hi    = cnt_q[0];
  assign req_b     = (state_q == S_IDLE) ? (b_in & MASK57) : b_q;
  assign cap_idx   = {1'b0, mul_resp_tag[3:0]} + {4'd0, mul_resp_tag[4]};

  // A write arriving together with start is parked and applied once the last request is out,
  // so the whole operation sees the old operands.
  always_comb begin
    wr_go      = 1'b0;
    wr_go_sel  = wr_sel;
    wr_go_idx  = wr_idx;
    wr_go_data = wr_data;
    if (wr_en && wr_open && !start_acc) begin
      wr_go = 1'b1;
    end else if (wrp_valid_q && (state_q == S_DRAIN) && !pend0_q) begin
      wr_go      = 1'b1;
      wr_go_sel  = wrp_sel_q;
      wr_go_idx  = wrp_idx_q;
      wr_go_data = wrp_data_q;
    end
  end

  always_comb begin
    req_a = '0;
    req_c = '0;
    for (int i = 0; i < NLIMB; i++) begin
      if (req_idx == 4'(i)) begin
        req_a = a_q[i];
        req_c = c_q[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NLIMB; gi++) begin : g_operand
      always_ff @(posedge clock) begin
        if (reset) begin
          a_q[gi] <= '0;
          c_q[gi] <= '0;
        end else if (wr_go && (wr_go_idx == 4'(gi))) begin
          if (wr_go_sel) c_q[gi] <= wr_go_data;
          else           a_q[gi] <= wr_go_data & MASK57;
        end
      end
    end

    // Low halves land on their own limb, high halves one limb up (tag carries the split).
    for (gi = 0; gi <= NLIMB; gi++) begin : g_result
      always_ff @(posedge clock) begin
        if (reset || start_acc) begin
          r_q[gi] <= '0;
        end else if (pend1_q && (cap_idx == 5'(gi))) begin
          r_q[gi] <= r_q[gi] + mul_resp_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend0_q     <= 1'b0;
      pend1_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_fn_q    <= '0;
      req_tag_q   <= '0;
      req_in1_q   <= '0;
      req_in2_q   <= '0;
      req_in3_q   <= '0;
      wrp_valid_q <= 1'b0;
      wrp_sel_q   <= 1'b0;
      wrp_idx_q   <= '0;
      wrp_data_q  <= '0;
    end else begin
      pend0_q <= req_valid_q;
      pend1_q <= pend0_q;
      done_q  <= 1'b0;
      if (issue_now) begin
        req_valid_q <= 1'b1;
        req_fn_q    <= req_hi ? FN_MADDH : FN_MADDL;
        req_tag_q   <= {req_hi, req_idx};
        req_in1_q   <= req_a;
        req_in2_q   <= req_b;
        req_in3_q   <= req_hi ? 64'd0 : req_c;
        cnt_q       <= cnt_q + 6'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (start_acc) begin
            state_q     <= S_ISSUE;
            b_q         <= b_in & MASK57;
            busy_q      <= 1'b1;
            wrp_valid_q <= wr_en;
            wrp_sel_q   <= wr_sel;
            wrp_idx_q   <= wr_idx;
            wrp_data_q  <= wr_data;
          end
        end
        S_ISSUE: begin
          if (cnt_q == 6'(NREQ)) begin
            req_valid_q <= 1'b0;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // pend0 clear here means the final response is being captured this cycle.
          if (!pend0_q) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            wrp_valid_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i <= NLIMB; i++) begin
      if (rd_idx == 5'(i)) rd_data = r_q[i];
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mul_req_valid = req_valid_q;
  assign mul_req_dw    = 1'b1;
  assign mul_req_fn    = req_fn_q;
  assign mul_req_tag   = req_tag_q;
  assign mul_req_in1   = req_in1_q;
  assign mul_req_in2   = req_in2_q;
  assign mul_req_in3   = req_in3_q;
endmodule

// File: tb/tb_xmul_limb_seq.sv
// Bench for xmul_limb_seq: behavioural 2-cycle multiplier, radix-2^57 reference model,
// table vectors, hand-written corner sequences and randomized operations.
module tb_xmul_limb_seq;
  localparam int N = 9;
  localparam logic [63:0] M57 = 64'h01FF_FFFF_FFFF_FFFF;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [63:0] b_in = '0;
  logic wr_en = 1'b0, wr_sel = 1'b0;
  logic [3:0] wr_idx = '0;
  logic [63:0] wr_data = '0;
  logic [4:0] rd_idx = '0;
  logic [63:0] rd_data;
  logic busy, done, mul_req_valid, mul_req_dw;
  logic [5:0] mul_req_fn;
  logic [4:0] mul_req_tag;
  logic [63:0] mul_req_in1, mul_req_in2, mul_req_in3;
  logic [63:0] mul_resp_data = '0;
  logic [4:0] mul_resp_tag = '0;

  xmul_limb_seq #(.NLIMB(N)) dut (
    .clock(clock), .reset(reset), .start(start), .b_in(b_in),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .done(done),
    .mul_req_valid(mul_req_valid), .mul_req_dw(mul_req_dw), .mul_req_fn(mul_req_fn),
    .mul_req_tag(mul_req_tag), .mul_req_in1(mul_req_in1), .mul_req_in2(mul_req_in2),
    .mul_req_in3(mul_req_in3), .mul_resp_data(mul_resp_data), .mul_resp_tag(mul_resp_tag)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Multiplier: request seen in cycle T answers during cycle T+2; idle slots carry noise.
  typedef struct {int cyc; logic [5:0] fn; logic [4:0] tag; logic [63:0] in1, in2, in3;} req_t;
  req_t trace[$];
  logic p0_v = 0, p1_v = 0;
  logic [63:0] p0_d = '0, p1_d = '0;
  logic [4:0] p0_t = '0, p1_t = '0;
  always @(negedge clock) begin
    logic [127:0] prod;
    if (p1_v) begin
      mul_resp_data = p1_d;
      mul_resp_tag  = p1_t;
    end else begin
      mul_resp_data = {$urandom, $urandom};
      mul_resp_tag  = 5'($urandom);
    end
    p1_v = p0_v; p1_d = p0_d; p1_t = p0_t;
    prod = 128'(mul_req_in1) * 128'(mul_req_in2);
    p0_v = mul_req_valid;
    p0_t = mul_req_tag;
    if (mul_req_fn == 6'd51) p0_d = 64'(prod >> 57) + mul_req_in3;
    else                     p0_d = 64'(prod[56:0]) + mul_req_in3;
    if (mul_req_valid) trace.push_back('{cyc, mul_req_fn, mul_req_tag, mul_req_in1, mul_req_in2, mul_req_in3});
  end

  logic [63:0] m_a [N], m_c [N], m_b, exp_r [N+1];
  logic [63:0] wa [N], wc [N];

  function automatic void model_compute();
    logic [127:0] p;
    for (int i = 0; i <= N; i++) exp_r[i] = '0;
    for (int i = 0; i < N; i++) begin
      p = 128'(m_a[i]) * 128'(m_b);
      exp_r[i]   = exp_r[i] + 64'(p[56:0]) + m_c[i];
      exp_r[i+1] = exp_r[i+1] + 64'(p >> 57);
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_limb(input logic sel, input int idx, input logic [63:0] d);
    wr_en = 1; wr_sel = sel; wr_idx = 4'(idx); wr_data = d;
    tick();
    wr_en = 0;
    if (idx < N) begin
      if (sel) m_c[idx] = d;
      else     m_a[idx] = d & M57;
    end
  endtask

  task automatic load_operands();
    for (int i = 0; i < N; i++) begin
      write_limb(1'b0, i, wa[i]);
      write_limb(1'b1, i, wc[i]);
    end
  endtask

  task automatic read_r(input int i, output logic [63:0] v);
    rd_idx = 5'(i);
    #1;
    v = rd_data;
  endtask

  task automatic check_result(input string tag);
    logic [63:0] v;
    model_compute();
    for (int i = 0; i <= N; i++) begin
      read_r(i, v);
      check($sformatf("%s_r%0d", tag, i), v, exp_r[i]);
    end
  endtask

  task automatic check_trace(input int s_cyc);
    check("trace_len", 64'(trace.size()), 64'(2 * N));
    for (int k = 0; k < trace.size() && k < 2 * N; k++) begin
      int i = k / 2;
      bit h = (k % 2) == 1;
      check($sformatf("tr%0d_cyc", k), 64'(trace[k].cyc), 64'(s_cyc + 1 + k));
      check($sformatf("tr%0d_fn", k), 64'(trace[k].fn), h ? 64'd51 : 64'd50);
      check($sformatf("tr%0d_tag", k), 64'(trace[k].tag), 64'(h ? 16 + i : i));
      check($sformatf("tr%0d_in1", k), trace[k].in1, m_a[i]);
      check($sformatf("tr%0d_in2", k), trace[k].in2, m_b);
      check($sformatf("tr%0d_in3", k), trace[k].in3, h ? 64'd0 : m_c[i]);
    end
  endtask

  // Starts an operation; optional disturbances at S+k. Returns early after a reset.
  task automatic run_op(input logic [63:0] b, input int restart_at, input int wr_at,
                        input int reset_at, input bit wr_with_start, output bit aborted);
    int s_cyc, done_at;
    trace.delete();
    s_cyc = cyc;
    start = 1; b_in = b;
    if (wr_with_start) begin wr_en = 1; wr_sel = 0; wr_idx = 0; wr_data = 64'd10; end
    tick();
    start = 0; wr_en = 0;
    m_b = b & M57;
    done_at = -1;
    aborted = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 1)         check("busy_first", 64'(busy), 64'd1);
      if (k == 2 * N + 2) check("busy_last", 64'(busy), 64'd1);
      if (done) begin
        done_at = k;
        check("busy_at_done", 64'(busy), 64'd0);
        break;
      end
      start = (k == restart_at);
      reset = (k == reset_at);
      if (k == wr_at) begin wr_en = 1; wr_sel = 0; wr_idx = 0; wr_data = 64'h123; end
      tick();
      start = 0; wr_en = 0;
      if (k == reset_at) begin
        reset = 0;
        aborted = 1;
        return;
      end
    end
    check("done_cycle", 64'(done_at), 64'(2 * N + 3));
    check_trace(s_cyc);
    if (wr_with_start) m_a[0] = 64'd10;
    tick();
    check("done_pulse_end", 64'(done), 64'd0);
  endtask

  typedef struct {string name; logic [63:0] a0, a1, c0, c1, b, r0, r1, r2;} vec_t;
  vec_t vecs[6];

  initial begin
    logic [63:0] v;
    bit ab;
    vecs[0] = '{"small", 64'd3, 64'd0, 64'd7, 64'd0, 64'd5, 64'd22, 64'd0, 64'd0};
    vecs[1] = '{"mask_a", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0, 64'd1, M57, 64'd0, 64'd0};
    vecs[2] = '{"hi_carry", 64'h0100_0000_0000_0000, 64'd0, 64'd9, 64'd5, 64'd4, 64'd9, 64'd7, 64'd0};
    vecs[3] = '{"max_b", 64'hFFFF_FFFF_FFFF_FFFF, M57, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                64'd1, M57, 64'h01FF_FFFF_FFFF_FFFE};
    vecs[4] = '{"c_wrap", 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 64'd0, 64'd0, 64'd0};
    vecs[5] = '{"limb1", 64'd0, 64'd2, 64'd4, 64'd100, 64'd3, 64'd4, 64'd106, 64'd0};
    for (int i = 0; i < N; i++) begin m_a[i] = '0; m_c[i] = '0; end

    reset = 1;
    tick(); tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(mul_req_valid), 64'd0);
    check("rst_fn", 64'(mul_req_fn), 64'd0);
    check("rst_tag", 64'(mul_req_tag), 64'd0);
    check("rst_in1", mul_req_in1, 64'd0);
    check("rst_in3", mul_req_in3, 64'd0);
    check("rst_dw", 64'(mul_req_dw), 64'd1);
    read_r(0, v); check("rst_r0", v, 64'd0);
    reset = 0;
    tick();

    // All-ones operands, full-width trace, then the same with start/write while busy.
    for (int i = 0; i < N; i++) begin wa[i] = M57; wc[i] = '0; end
    load_operands();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) run_op(M57, -1, -1, -1, 0, ab);
      else           run_op(M57, 4, 6, -1, 0, ab);
      read_r(0, v); check($sformatf("ones%0d_r0", pass), v, 64'd1);
      for (int i = 1; i < N; i++) begin
        read_r(i, v); check($sformatf("ones%0d_r%0d", pass, i), v, M57);
      end
      read_r(N, v); check($sformatf("ones%0d_r9", pass), v, 64'h01FF_FFFF_FFFF_FFFE);
      $display("op ones pass=%0d r0=%h", pass, exp_r[0]);
    end

    // Reset during ISSUE drops in-flight work and operands.
    run_op(M57, -1, -1, 5, 0, ab);
    check("rr_aborted", 64'(ab), 64'd1);
    check("rr_valid", 64'(mul_req_valid), 64'd0);
    check("rr_busy", 64'(busy), 64'd0);
    for (int i = 0; i <= N; i++) begin read_r(i, v); check($sformatf("rr_r%0d", i), v, 64'd0); end
    for (int i = 0; i < N; i++) begin m_a[i] = '0; m_c[i] = '0; end
    tick(); tick(); tick();
    read_r(1, v); check("rr_late_r1", v, 64'd0);
    $display("op reset_mid_issue");

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) begin wa[i] = '0; wc[i] = '0; end
      wa[0] = vecs[t].a0; wa[1] = vecs[t].a1; wc[0] = vecs[t].c0; wc[1] = vecs[t].c1;
      load_operands();
      run_op(vecs[t].b, -1, -1, -1, 0, ab);
      read_r(0, v); check({vecs[t].name, "_r0"}, v, vecs[t].r0);
      read_r(1, v); check({vecs[t].name, "_r1"}, v, vecs[t].r1);
      read_r(2, v); check({vecs[t].name, "_r2"}, v, vecs[t].r2);
      read_r(N, v); check({vecs[t].name, "_r9"}, v, 64'd0);
      $display("op vec %s r0=%h r1=%h", vecs[t].name, vecs[t].r0, vecs[t].r1);
    end
    read_r(20, v); check("rd_oob20", v, 64'd0);
    read_r(10, v); check("rd_oob10", v, 64'd0);

    // Write in the start cycle: old a0 used now, new a0 afterwards.
    for (int i = 0; i < N; i++) begin wa[i] = '0; wc[i] = '0; end
    wa[0] = 64'd3;
    load_operands();
    run_op(64'd5, -1, -1, -1, 1, ab);
    read_r(0, v); check("wrstart_old_r0", v, 64'd15);
    run_op(64'd5, -1, -1, -1, 0, ab);
    read_r(0, v); check("wrstart_new_r0", v, 64'd50);
    $display("op write_with_start");

    // Randomized operations against the reference model, including dropped writes.
    for (int n = 0; n < 20; n++) begin
      int nw = $urandom_range(4, 24);
      for (int w = 0; w < nw; w++) begin
        logic [63:0] d = {$urandom, $urandom};
        bit sel = $urandom_range(0, 1) == 1;
        if (sel && $urandom_range(0, 3) != 0) d = d >> 2;
        write_limb(sel, $urandom_range(0, 15), d);
      end
      run_op({$urandom, $urandom}, -1, -1, -1, 0, ab);
      check_result($sformatf("rnd%0d", n));
      $display("op rnd %0d b=%h r0=%h r9=%h", n, m_b, exp_r[0], exp_r[N]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
